fibo_seq_checker: RTL and testbench



---
 rtl/fibo_seq_checker_if.sv | 28 ++
 rtl/fibo_seq_checker.sv | 127 ++++++++++++
 tb/tb_fibo_seq_checker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fibo_seq_checker_if.sv
// Term bus between the Fibonacci generator side and its checker.
// The generator/bench side is the master; the checker is the slave.
interface fibo_seq_checker_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
);
   logic [WIDTH-1:0] fibo_in;
   logic             in_valid;
   logic             clr;
   logic [WIDTH-1:0] expected;
   logic             mismatch;
   logic             error;
   logic [CNT_W-1:0] first_err_idx;
   logic [CNT_W-1:0] term_count;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] wrap_count;
   logic [1:0]       state;

   modport master (
      output fibo_in, in_valid, clr,
      input  expected, mismatch, error, first_err_idx, term_count, err_count, wrap_count, state
   );

   modport slave (
      input  fibo_in, in_valid, clr,
      output expected, mismatch, error, first_err_idx, term_count, err_count, wrap_count, state
   );
endinterface

// File: rtl/fibo_seq_checker.sv
// Fibonacci stream checker: predicts each term from the two previously observed terms,
// flags mismatches and keeps saturating term/error/wrap statistics.
module fibo_seq_checker #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   fibo_seq_checker_if.slave  bus
);

   typedef enum logic [1:0] {
      StSeed0 = 2'd0,
      StSeed1 = 2'd1,
      StCheck = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic [WIDTH-1:0] prev1_q, prev1_d;
   logic [WIDTH-1:0] prev2_q, prev2_d;
   logic             mismatch_q, mismatch_d;
   logic             error_q, error_d;
   logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
   logic [CNT_W-1:0] term_count_q, term_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
   logic [WIDTH:0]   sum;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      state_d         = state_q;
      expected_d      = expected_q;
      prev1_d         = prev1_q;
      prev2_d         = prev2_q;
      mismatch_d      = 1'b0;
      error_d         = error_q;
      first_err_idx_d = first_err_idx_q;
      term_count_d    = term_count_q;
      err_count_d     = err_count_q;
      wrap_count_d    = wrap_count_q;
      sum             = '0;

      if (bus.clr) begin
         state_d         = StSeed0;
         expected_d      = '0;
         prev1_d         = '0;
         prev2_d         = '0;
         error_d         = 1'b0;
         first_err_idx_d = '0;
         term_count_d    = '0;
         err_count_d     = '0;
         wrap_count_d    = '0;
      end else if (bus.in_valid) begin
         mismatch_d   = (bus.fibo_in != expected_q);
         term_count_d = sat_inc(term_count_q);
         if (mismatch_d) begin
            err_count_d = sat_inc(err_count_q);
            error_d     = 1'b1;
            if (!error_q) first_err_idx_d = term_count_q;
         end

         // Prediction re-seeds from the observed term so one bad term gives one mismatch.
         unique case (state_q)
            StSeed0: begin
               prev2_d    = bus.fibo_in;
               expected_d = WIDTH'(1);
               state_d    = StSeed1;
            end
            StSeed1: begin
               prev1_d    = bus.fibo_in;
               sum        = {1'b0, prev2_q} + {1'b0, bus.fibo_in};
               expected_d = sum[WIDTH-1:0];
               state_d    = StCheck;
            end
            StCheck: begin
               prev2_d    = prev1_q;
               prev1_d    = bus.fibo_in;
               sum        = {1'b0, prev1_q} + {1'b0, bus.fibo_in};
               expected_d = sum[WIDTH-1:0];
            end
            default: state_d = StSeed0;
         endcase

         if (sum[WIDTH]) wrap_count_d = sat_inc(wrap_count_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= StSeed0;
         expected_q      <= '0;
         prev1_q         <= '0;
         prev2_q         <= '0;
         mismatch_q      <= 1'b0;
         error_q         <= 1'b0;
         first_err_idx_q <= '0;
         term_count_q    <= '0;
         err_count_q     <= '0;
         wrap_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         expected_q      <= expected_d;
         prev1_q         <= prev1_d;
         prev2_q         <= prev2_d;
         mismatch_q      <= mismatch_d;
         error_q         <= error_d;
         first_err_idx_q <= first_err_idx_d;
         term_count_q    <= term_count_d;
         err_count_q     <= err_count_d;
         wrap_count_q    <= wrap_count_d;
      end
   end

   assign bus.expected      = expected_q;
   assign bus.mismatch      = mismatch_q;
   assign bus.error         = error_q;
   assign bus.first_err_idx = first_err_idx_q;
   assign bus.term_count    = term_count_q;
   assign bus.err_count     = err_count_q;
   assign bus.wrap_count    = wrap_count_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_fibo_seq_checker.sv
// Directed bench for fibo_seq_checker: default build plus a CNT_W=2 build for saturation.
module tb_fibo_seq_checker;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   fibo_seq_checker_if #(.WIDTH(4), .CNT_W(8)) bus ();
   fibo_seq_checker_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

   fibo_seq_checker #(.WIDTH(4), .CNT_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   fibo_seq_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus2.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic v, input logic [3:0] d, input logic c);
      bus.in_valid = v;
      bus.fibo_in  = d;
      bus.clr      = c;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.clr      = 1'b0;
   endtask

   task automatic step2(input logic [3:0] d);
      bus2.in_valid = 1'b1;
      bus2.fibo_in  = d;
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
   endtask

   logic [3:0] good [13] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5, 4'd2,
                             4'd7, 4'd9, 4'd0};

   initial begin
      checks        = 0;
      failures      = 0;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.fibo_in   = '0;
      bus.clr       = 1'b0;
      bus2.in_valid = 1'b0;
      bus2.fibo_in  = '0;
      bus2.clr      = 1'b0;
      #12;
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_expected", 32'(bus.expected), 0);
      chk("rst_term_count", 32'(bus.term_count), 0);
      chk("rst_error", 32'(bus.error), 0);
      reset_n = 1'b1;

      // Clean 13-term stream with three wraps.
      for (int i = 0; i < 13; i++) begin
         step(1'b1, good[i], 1'b0);
         chk($sformatf("good_mismatch_%0d", i), 32'(bus.mismatch), 0);
      end
      chk("good_error", 32'(bus.error), 0);
      chk("good_term_count", 32'(bus.term_count), 13);
      chk("good_wrap_count", 32'(bus.wrap_count), 3);
      chk("good_expected", 32'(bus.expected), 9);
      chk("good_state", 32'(bus.state), 2);
      chk("good_err_count", 32'(bus.err_count), 0);

      // Restart, then corrupt index 4 (4 instead of 3).
      step(1'b0, 4'd0, 1'b1);
      chk("clr_state", 32'(bus.state), 0);
      chk("clr_term_count", 32'(bus.term_count), 0);
      chk("clr_wrap_count", 32'(bus.wrap_count), 0);
      step(1'b1, 4'd0, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      chk("bad_pre_mismatch", 32'(bus.mismatch), 0);
      step(1'b1, 4'd4, 1'b0);
      chk("bad_mismatch", 32'(bus.mismatch), 1);
      chk("bad_error", 32'(bus.error), 1);
      chk("bad_first_idx", 32'(bus.first_err_idx), 4);
      chk("bad_err_count", 32'(bus.err_count), 1);
      chk("bad_expected_reseed", 32'(bus.expected), 6);
      step(1'b0, 4'd0, 1'b0);
      chk("bad_pulse_end", 32'(bus.mismatch), 0);
      chk("bad_error_sticky", 32'(bus.error), 1);
      step(1'b1, 4'd6, 1'b0);
      chk("bad_resume_mismatch", 32'(bus.mismatch), 0);
      chk("bad_resume_expected", 32'(bus.expected), 10);
      chk("bad_resume_err_count", 32'(bus.err_count), 1);
      chk("bad_resume_term_count", 32'(bus.term_count), 6);

      // clr with a valid term: the term is discarded.
      step(1'b1, 4'd7, 1'b1);
      chk("clrv_state", 32'(bus.state), 0);
      chk("clrv_term_count", 32'(bus.term_count), 0);
      chk("clrv_err_count", 32'(bus.err_count), 0);
      chk("clrv_error", 32'(bus.error), 0);
      chk("clrv_first_idx", 32'(bus.first_err_idx), 0);
      chk("clrv_expected", 32'(bus.expected), 0);

      // Valid gaps: 1,0,0,1.
      step(1'b1, 4'd0, 1'b0);
      chk("gap_term1", 32'(bus.term_count), 1);
      chk("gap_exp1", 32'(bus.expected), 1);
      step(1'b0, 4'd9, 1'b0);
      step(1'b0, 4'd9, 1'b0);
      chk("gap_hold_term", 32'(bus.term_count), 1);
      chk("gap_hold_exp", 32'(bus.expected), 1);
      chk("gap_hold_state", 32'(bus.state), 1);
      chk("gap_hold_mismatch", 32'(bus.mismatch), 0);
      step(1'b1, 4'd1, 1'b0);
      chk("gap_term2", 32'(bus.term_count), 2);
      chk("gap_mismatch", 32'(bus.mismatch), 0);
      chk("gap_state", 32'(bus.state), 2);

      // Mid-stream error, then asynchronous reset between edges.
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd5, 1'b0);
      chk("ar_pre_mismatch", 32'(bus.mismatch), 1);
      chk("ar_pre_error", 32'(bus.error), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_mismatch", 32'(bus.mismatch), 0);
      chk("ar_error", 32'(bus.error), 0);
      chk("ar_term_count", 32'(bus.term_count), 0);
      chk("ar_err_count", 32'(bus.err_count), 0);
      chk("ar_state", 32'(bus.state), 0);
      chk("ar_expected", 32'(bus.expected), 0);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 4'd0, 1'b0);
      chk("ar_post_m0", 32'(bus.mismatch), 0);
      step(1'b1, 4'd1, 1'b0);
      chk("ar_post_m1", 32'(bus.mismatch), 0);
      step(1'b1, 4'd1, 1'b0);
      chk("ar_post_m2", 32'(bus.mismatch), 0);
      chk("ar_post_term", 32'(bus.term_count), 3);
      chk("ar_post_expected", 32'(bus.expected), 2);
      chk("ar_post_error", 32'(bus.error), 0);

      // CNT_W=2 build: term_count saturates at 3.
      for (int i = 0; i < 3; i++) step2(good[i]);
      chk("sat_term3", 32'(bus2.term_count), 3);
      step2(good[3]);
      step2(good[4]);
      chk("sat_term5", 32'(bus2.term_count), 3);
      chk("sat_mismatch", 32'(bus2.mismatch), 0);
      chk("sat_expected", 32'(bus2.expected), 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
